kmeans_mean_scheduler: RTL
==========================

# kmeans_mean_scheduler

Sequences one shared pipelined divider across all clusters to compute the K-means centroid update. For each cluster it computes mean_x = sum_x / count and mean_y = sum_y / count. It sits between the cluster accumulators and the divider wrapper. It snapshots the sums and counts on start, issues one division per cycle, matches returning quotients to their cluster and axis with a tag pipeline, and signals done when every mean register is updated.

## Interface
- NUM_CLUSTERS, 4: number of clusters K (1..16).
- SUM_W, 20: dividend / sum / mean width.
- CNT_W, 12: divisor / count width.
- DIV_LATENCY, 24: fixed cycles from divider input to quotient output while div_ce=1 (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a mean update.
- sum_x  in  NUM_CLUSTERS*SUM_W  per-cluster x sums, cluster k at [k*SUM_W +: SUM_W].
- sum_y  in  NUM_CLUSTERS*SUM_W  per-cluster y sums, same packing.
- count  in  NUM_CLUSTERS*CNT_W  per-cluster member counts.
- div_ce  out  1  divider clock enable.
- div_sclr  out  1  divider synchronous clear (active-high).
- div_dividend  out  SUM_W  divider dividend.
- div_divisor  out  CNT_W  divider divisor.
- div_quotient  in  SUM_W  divider quotient.
- mean_x  out  NUM_CLUSTERS*SUM_W  registered x centroids.
- mean_y  out  NUM_CLUSTERS*SUM_W  registered y centroids.
- mean_valid  out  NUM_CLUSTERS  per-cluster "updated in the current run".
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the run completes.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 snapshots sum_x, sum_y and count into internal registers.
  - Clears mean_valid to 0.
  - Goes to ISSUE.
- ISSUE: runs 2K slots, slot s = 0..2K-1, one per cycle.
  - Cluster k = s>>1.
  - Axis = x when s is even, y when s is odd.
  - div_dividend = snapshot sum for that cluster and axis; div_divisor = snapshot count[k].
  - After slot 2K-1, goes to DRAIN.
- Zero-count cluster:
  - Its slot is still consumed, but issues dividend 0 / divisor 1.
  - That slot's tag is invalid. Its result is discarded; mean_x/mean_y[k] keep their previous values and mean_valid[k] stays 0.
- Tag pipeline: DIV_LATENCY-deep shift register of {valid, cluster, axis}. It advances every cycle while div_ce=1.
- Capture: at the head of the tag pipeline, a valid tag writes div_quotient into the addressed mean register. mean_valid[k] is set when cluster k's y result is written.
- DRAIN:
  - Keeps div_ce=1 and inputs at 0/1 with invalid tags until the last issued tag is captured.
  - Then pulses done and returns to IDLE.
- div_ce = busy. The divider is never stalled mid-run; no quotient is taken while div_ce=0.
- div_sclr = !rst_n, combinational. This flushes the divider together with the scheduler.
- start while busy: ignored, no queuing.
- Quotient is unsigned integer division, truncated; fractional output is unused.
- Inputs may change freely after the start cycle; only the snapshot is used.

## Timing
- Reset values (rst_n=0 at an edge):
  - State IDLE; busy=0, done=0, div_ce=0.
  - div_dividend=0, div_divisor=1.
  - All tags invalid; mean_x=0, mean_y=0, mean_valid=0.
- Reset mid-run aborts immediately. No done pulse; partial means are cleared to 0.
- Start accepted at edge t0:
  - busy=1 from t0+1.
  - Slot s is on the divider inputs during cycle t0+1+s.
  - Its result is captured at edge t0+1+s+DIV_LATENCY.
- Last capture is at edge t0+2K+DIV_LATENCY.
- done=1 and busy=0 during the following cycle. Total start-to-done = 2K+DIV_LATENCY+1 cycles (33 at defaults).
- start may be reasserted in the cycle done is high: it is accepted (state is IDLE).

## Test plan
- K=4, L=24, sums x={100,250,36,4095}, y={50,1000,12,7}, counts={10,5,6,3} -> means x={10,50,6,1365}, y={5,200,2,2}; mean_valid=4'b1111; done exactly 33 cycles after start.
- count[2]=0, previous mean_x[2]=77 -> mean_x[2]=77 retained, mean_valid=4'b1011, other clusters correct, same latency.
- start re-pulsed at cycles 5 and 20 of a run -> ignored; single done; results match the first snapshot; inputs changed after start have no effect.
- rst_n low for 1 cycle at cycle 15 of a run -> next cycle busy=0, all means 0, div_sclr=1 during reset, no done; a fresh start then completes in 33 cycles.
- Back-to-back: start asserted in the done cycle -> second run accepted with no gap; busy low for only that one cycle.
- Max values: sum=20'hFFFFF, count=1 -> mean=20'hFFFFF; count=12'hFFF -> mean=256.

Source files
------------

// File: rtl/kmeans_mean_scheduler.sv
// kmeans_mean_scheduler: time-shares one pipelined divider across all clusters to refresh centroid means.
module kmeans_mean_scheduler #(
  parameter int NUM_CLUSTERS = 4,
  parameter int SUM_W = 20,
  parameter int CNT_W = 12,
  parameter int DIV_LATENCY = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [NUM_CLUSTERS*SUM_W-1:0] sum_x,
  input  logic [NUM_CLUSTERS*SUM_W-1:0] sum_y,
  input  logic [NUM_CLUSTERS*CNT_W-1:0] count,
  output logic div_ce,
  output logic div_sclr,
  output logic [SUM_W-1:0] div_dividend,
  output logic [CNT_W-1:0] div_divisor,
  input  logic [SUM_W-1:0] div_quotient,
  output logic [NUM_CLUSTERS*SUM_W-1:0] mean_x,
  output logic [NUM_CLUSTERS*SUM_W-1:0] mean_y,
  output logic [NUM_CLUSTERS-1:0] mean_valid,
  output logic busy,
  output logic done
);
  localparam int KW = NUM_CLUSTERS > 1 ? $clog2(NUM_CLUSTERS) : 1;
  localparam int CW = $clog2(2*NUM_CLUSTERS + DIV_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] ctr;
  logic [NUM_CLUSTERS*SUM_W-1:0] snap_x, snap_y;
  logic [NUM_CLUSTERS*CNT_W-1:0] snap_c;
  logic tv [DIV_LATENCY];
  logic [KW-1:0] tk [DIV_LATENCY];
  logic ta [DIV_LATENCY];
  logic [KW-1:0] k;
  logic axis;
  logic [CNT_W-1:0] c;
  logic live;
  assign div_ce = busy;
  assign div_sclr = !rst_n;
  // Zero-count slots still occupy the divider, but with a harmless 0/1 and an invalid tag.
  always_comb begin
    k = KW'(ctr >> 1);
    axis = ctr[0];
    c = snap_c[k*CNT_W +: CNT_W];
    live = (state == ISSUE) && (c != '0);
    div_dividend = !live ? '0 : axis ? snap_y[k*SUM_W +: SUM_W] : snap_x[k*SUM_W +: SUM_W];
    div_divisor = live ? c : CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      ctr <= '0;
      snap_x <= '0;
      snap_y <= '0;
      snap_c <= '0;
      mean_x <= '0;
      mean_y <= '0;
      mean_valid <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        tv[i] <= 1'b0;
        tk[i] <= '0;
        ta[i] <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      if (busy) begin
        tv[0] <= live;
        tk[0] <= k;
        ta[0] <= axis;
        for (int i = 1; i < DIV_LATENCY; i++) begin
          tv[i] <= tv[i-1];
          tk[i] <= tk[i-1];
          ta[i] <= ta[i-1];
        end
        if (tv[DIV_LATENCY-1]) begin
          if (ta[DIV_LATENCY-1]) begin
            mean_y[tk[DIV_LATENCY-1]*SUM_W +: SUM_W] <= div_quotient;
            mean_valid[tk[DIV_LATENCY-1]] <= 1'b1;
          end else begin
            mean_x[tk[DIV_LATENCY-1]*SUM_W +: SUM_W] <= div_quotient;
          end
        end
      end
      case (state)
        IDLE: if (start) begin
          snap_x <= sum_x;
          snap_y <= sum_y;
          snap_c <= count;
          mean_valid <= '0;
          ctr <= '0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          ctr <= ctr == CW'(2*NUM_CLUSTERS-1) ? '0 : ctr + 1'b1;
          if (ctr == CW'(2*NUM_CLUSTERS-1)) state <= DRAIN;
        end
        DRAIN: if (ctr == CW'(DIV_LATENCY-1)) begin
          ctr <= '0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end else begin
          ctr <= ctr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
